// File: rtl/fft_ctrl_if.sv
// Bundles the FFT controller handshake, memory-address and datapath-control signals.
// Optional abort input is present only when FFT_CTRL_ABORT_EN is defined.
interface fft_ctrl_if #(
    parameter int unsigned N_LOG2 = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic [N_LOG2-1:0] addr0_rd;
    logic [N_LOG2-1:0] addr1_rd;
    logic [N_LOG2-1:0] addr0_wr;
    logic [N_LOG2-1:0] addr1_wr;
    logic              we_AMEM;
    logic              we_BMEM;
    logic [N_LOG2-2:0] addr_CROM;
    logic              sel_mux;
    logic              en_REG;
    logic              res_in_BMEM;
`ifdef FFT_CTRL_ABORT_EN
    logic              abort;
`endif

    modport master (
        input  start,
        output busy, done, addr0_rd, addr1_rd, addr0_wr, addr1_wr,
        output we_AMEM, we_BMEM, addr_CROM, sel_mux, en_REG, res_in_BMEM
`ifdef FFT_CTRL_ABORT_EN
        , input abort
`endif
    );

    modport slave (
        output start,
        input  busy, done, addr0_rd, addr1_rd, addr0_wr, addr1_wr,
        input  we_AMEM, we_BMEM, addr_CROM, sel_mux, en_REG, res_in_BMEM
`ifdef FFT_CTRL_ABORT_EN
        , output abort
`endif
    );
endinterface

// File: rtl/fft_ctrl.sv
// Radix-2 in-place FFT address/control sequencer, ping-ponging between AMEM and BMEM.
// Define FFT_CTRL_ABORT_EN to add the abort input to the bus.
module fft_ctrl #(
    parameter int unsigned N_LOG2 = 5
) (
    input logic       clk,
    input logic       rstn,
    fft_ctrl_if.master bus
);
    localparam int unsigned BW = N_LOG2 - 1;
    localparam int unsigned SW = $clog2(N_LOG2);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   b_q, b_d;
    logic [SW-1:0]   s_q, s_d;
    logic            f_q, f_d;
    logic            busy_q, busy_d;
    logic            rd_v;
    logic            kill;
    logic            abort;

    // Two-stage butterfly pipeline: stage 1 = operand load, stage 2 = result write.
    logic            v1_q, p1_q, v2_q, p2_q;
    logic [N_LOG2-1:0] a0_1_q, a1_1_q, a0_2_q, a1_2_q;

    logic [N_LOG2-1:0] b_ext, half, low, hi, a0, a1;
    logic [SW-1:0]     crom_sh;
    logic [BW-1:0]     crom;

`ifdef FFT_CTRL_ABORT_EN
    assign abort = bus.abort;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        s_d     = s_q;
        f_d     = f_q;
        rd_v    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    b_d     = '0;
                    s_d     = '0;
                end
            end
            StRun: begin
                rd_v = 1'b1;
                if (b_q == '1) begin
                    b_d     = '0;
                    f_d     = 1'b0;
                    state_d = StFlush;
                end else begin
                    b_d = b_q + 1'b1;
                end
            end
            StFlush: begin
                f_d = 1'b1;
                if (f_q) begin
                    f_d = 1'b0;
                    if (s_q == SW'(N_LOG2 - 1)) begin
                        s_d     = '0;
                        state_d = StDone;
                    end else begin
                        s_d     = s_q + 1'b1;
                        state_d = StRun;
                    end
                end
            end
            StDone: state_d = StIdle;
        endcase

        kill = abort && (state_q == StRun || state_q == StFlush);
        if (kill) begin
            state_d = StIdle;
            b_d     = '0;
            s_d     = '0;
            f_d     = 1'b0;
        end

        // Busy drops on the edge that enters DONE and rises one edge after start.
        busy_d = (state_q == StRun || state_q == StFlush) &&
                 (state_d == StRun || state_d == StFlush);
    end

    always_comb begin
        b_ext   = {1'b0, b_q};
        half    = N_LOG2'(1) << s_q;
        low     = b_ext & (half - N_LOG2'(1));
        hi      = ((b_ext >> s_q) << s_q) << 1;
        a0      = hi | low;
        a1      = a0 + half;
        crom_sh = SW'(N_LOG2 - 1) - s_q;
        crom    = low[BW-1:0] << crom_sh;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            b_q     <= '0;
            s_q     <= '0;
            f_q     <= 1'b0;
            busy_q  <= 1'b0;
            v1_q    <= 1'b0;
            p1_q    <= 1'b0;
            a0_1_q  <= '0;
            a1_1_q  <= '0;
            v2_q    <= 1'b0;
            p2_q    <= 1'b0;
            a0_2_q  <= '0;
            a1_2_q  <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            s_q     <= s_d;
            f_q     <= f_d;
            busy_q  <= busy_d;
            v1_q    <= rd_v && !kill;
            p1_q    <= rd_v && !kill && s_q[0];
            a0_1_q  <= (rd_v && !kill) ? a0 : '0;
            a1_1_q  <= (rd_v && !kill) ? a1 : '0;
            v2_q    <= v1_q && !kill;
            p2_q    <= p1_q && !kill;
            a0_2_q  <= kill ? '0 : a0_1_q;
            a1_2_q  <= kill ? '0 : a1_1_q;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = (state_q == StDone);
    assign bus.addr0_rd    = (state_q == StRun) ? a0 : '0;
    assign bus.addr1_rd    = (state_q == StRun) ? a1 : '0;
    assign bus.addr_CROM   = (state_q == StRun) ? crom : '0;
    assign bus.en_REG      = ~v1_q;
    assign bus.sel_mux     = p1_q;
    assign bus.addr0_wr    = a0_2_q;
    assign bus.addr1_wr    = a1_2_q;
    // Even stages write BMEM, odd stages write AMEM.
    assign bus.we_AMEM     = v2_q & p2_q;
    assign bus.we_BMEM     = v2_q & ~p2_q;
    assign bus.res_in_BMEM = 1'(N_LOG2 % 2);
endmodule

// File: tb/tb_fft_ctrl.sv
// Randomized bench for fft_ctrl (N_LOG2=3) against a per-cycle schedule model.
module tb_fft_ctrl;
    localparam int unsigned L     = 3;
    localparam int          H     = 4;
    localparam int          P     = H + 2;
    localparam int          TOTAL = L * P;

    logic clk = 1'b0;
    logic rstn;
    logic start;
    logic abort;

    always #5 clk = ~clk;

    fft_ctrl_if #(.N_LOG2(L)) bus ();
    fft_ctrl #(.N_LOG2(L)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    assign bus.start = start;
`ifdef FFT_CTRL_ABORT_EN
    assign bus.abort = abort;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_vec();
        return {12'b0, bus.busy, bus.done, bus.addr0_rd, bus.addr1_rd, bus.addr0_wr,
                bus.addr1_wr, bus.we_AMEM, bus.we_BMEM, bus.addr_CROM, bus.sel_mux, bus.en_REG};
    endfunction

    // Butterfly read issued in cycle c (cycles counted from the edge that sampled start).
    function automatic bit read_at(input int c, output int s, output int a0, output int a1,
                                   output int cr);
        int b, half;
        s = 0; a0 = 0; a1 = 0; cr = 0;
        if (c < 0 || c >= TOTAL || (c % P) >= H) return 1'b0;
        s    = c / P;
        b    = c % P;
        half = 1 << s;
        a0   = (b / half) * 2 * half + (b % half);
        a1   = a0 + half;
        cr   = (b % half) << (L - 1 - s);
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_vec(input int c);
        int s0, ra0, ra1, cr, s1, x0, x1, xc, s2, wa0, wa1, wc;
        bit r1, r2;
        logic busy, done, we_a, we_b, sel, en;
        void'(read_at(c, s0, ra0, ra1, cr));
        r1   = read_at(c - 1, s1, x0, x1, xc);
        r2   = read_at(c - 2, s2, wa0, wa1, wc);
        en   = !r1;
        sel  = r1 && (s1 % 2 == 1);
        we_a = r2 && (s2 % 2 == 1);
        we_b = r2 && (s2 % 2 == 0);
        busy = (c >= 1) && (c <= TOTAL - 1);
        done = (c == TOTAL);
        return {12'b0, busy, done, 3'(ra0), 3'(ra1), 3'(wa0), 3'(wa1), we_a, we_b,
                2'(cr), sel, en};
    endfunction

    // kind: 0 = run to completion, 1 = reset at kill_at, 2 = abort at kill_at.
    task automatic run_txn(input int kind, input int kill_at, input bit repulse);
        int busy_cnt = 0;
        int gap = $urandom_range(1, 4);
        repeat (gap) begin
            @(negedge clk);
            check_eq("idle", obs_vec(), exp_vec(-1));
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= TOTAL + 1; c++) begin
            check_eq($sformatf("k%0d_c%0d", kind, c), obs_vec(), exp_vec(c));
            if (bus.busy) busy_cnt++;
            if (kind != 0 && c == kill_at) begin
                start = 1'b0;
                if (kind == 1) rstn = 1'b0;
                else abort = 1'b1;
                @(negedge clk);
                rstn  = 1'b1;
                abort = 1'b0;
                repeat (3) begin
                    check_eq($sformatf("killed_k%0d_c%0d", kind, c), obs_vec(), exp_vec(-1));
                    @(negedge clk);
                end
                return;
            end
            start = (repulse && c <= TOTAL) ? ($urandom_range(0, 2) == 0) : 1'b0;
            @(negedge clk);
        end
        check_eq("busy_cycles", 32'(busy_cnt), 32'(TOTAL - 1));
    endtask

    initial begin
        rstn  = 1'b0;
        start = 1'b1;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_vec", obs_vec(), exp_vec(-1));
        check_eq("res_in_BMEM", 32'(bus.res_in_BMEM), 32'd1);
        start = 1'b0;
        @(negedge clk);
        check_eq("reset_vec2", obs_vec(), exp_vec(-1));
        rstn = 1'b1;

        run_txn(0, 0, 1'b0);
        run_txn(0, 0, 1'b1);
        run_txn(1, $urandom_range(P, P + H - 1), 1'b1);
        run_txn(1, $urandom_range(0, TOTAL), 1'b0);
        run_txn(0, 0, 1'b1);
`ifdef FFT_CTRL_ABORT_EN
        run_txn(2, H + $urandom_range(0, 1), 1'b0);
        run_txn(0, 0, 1'b0);
        run_txn(2, $urandom_range(0, TOTAL - 1), 1'b1);
`endif
        run_txn(0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
